// File: rtl/host_cmd_master.sv
// Host command master: serialises register-file / ALU commands into UART byte
// frames, then collects up to two response bytes with a per-byte timeout.
module host_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUNC_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA_A,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA_B,
  input  logic [FUNC_WIDTH-1:0]   CMD_FUNC,
  output logic [DATA_WIDTH-1:0]   TX_BYTE,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  input  logic [DATA_WIDTH-1:0]   RX_BYTE,
  input  logic                    RX_VALID,
  input  logic                    RX_ERROR,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VALID,
  output logic                    RSP_ERR,
  output logic                    BUSY
);

  // state    | meaning
  // IDLE     | ready for a command
  // SEND     | transmitting frame bytes
  // WAIT_RSP | collecting response bytes, timeout running
  // DONE     | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  localparam logic [1:0] CMD_WR  = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_OP  = 2'd2;
  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state, state_nxt;
  logic [1:0]              typ_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [FUNC_WIDTH-1:0]   func_q;
  logic [1:0]              byte_idx;
  logic [1:0]              rx_cnt;
  logic [TW-1:0]           to_cnt;
  logic                    err_q;
  logic [2*DATA_WIDTH-1:0] rsp_q;

  logic                    accept, tx_hs, tx_last, rx_last, timeout;
  logic [1:0]              last_idx, rsp_len;
  logic [DATA_WIDTH-1:0]   frame_byte, addr_ext, func_ext;

  assign addr_ext = DATA_WIDTH'(addr_q);
  assign func_ext = DATA_WIDTH'(func_q);
  assign accept   = CMD_VALID && (state == IDLE);
  assign tx_hs    = (state == SEND) && TX_READY;
  assign tx_last  = tx_hs && (byte_idx == last_idx);
  assign rx_last  = RX_VALID && (rx_cnt == rsp_len - 2'd1);
  assign timeout  = !RX_VALID && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    last_idx   = 2'd1;
    rsp_len    = 2'd2;
    frame_byte = '0;
    case (typ_q)
      CMD_WR: begin
        last_idx = 2'd2;
        rsp_len  = 2'd0;
        case (byte_idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hAA);
          2'd1:    frame_byte = addr_ext;
          default: frame_byte = a_q;
        endcase
      end
      CMD_RD: begin
        rsp_len    = 2'd1;
        frame_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : addr_ext;
      end
      CMD_OP: begin
        last_idx = 2'd3;
        case (byte_idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hCC);
          2'd1:    frame_byte = a_q;
          2'd2:    frame_byte = b_q;
          default: frame_byte = func_ext;
        endcase
      end
      default: begin
        frame_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : func_ext;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SEND;
      SEND:     if (tx_last) state_nxt = (typ_q == CMD_WR) ? DONE : WAIT_RSP;
      WAIT_RSP: if (RX_ERROR || rx_last || timeout) state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      typ_q    <= '0;
      addr_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      byte_idx <= '0;
      rx_cnt   <= '0;
      to_cnt   <= '0;
      err_q    <= 1'b0;
      rsp_q    <= '0;
    end else begin
      if (accept) begin
        typ_q    <= CMD_TYPE;
        addr_q   <= CMD_ADDR;
        a_q      <= CMD_DATA_A;
        b_q      <= CMD_DATA_B;
        func_q   <= CMD_FUNC;
        byte_idx <= '0;
        rx_cnt   <= '0;
        to_cnt   <= '0;
        err_q    <= 1'b0;
        rsp_q    <= '0;
      end
      if (tx_hs) byte_idx <= byte_idx + 2'd1;
      if (state == WAIT_RSP) begin
        // a byte arriving alongside RX_ERROR is still kept
        if (RX_VALID) begin
          if (rx_cnt == 2'd0) rsp_q[DATA_WIDTH-1:0]            <= RX_BYTE;
          else                rsp_q[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_BYTE;
          rx_cnt <= rx_cnt + 2'd1;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
        if (RX_ERROR || timeout) err_q <= 1'b1;
      end
    end
  end

  assign CMD_READY = (state == IDLE);
  assign TX_VALID  = (state == SEND);
  assign TX_BYTE   = (state == SEND) ? frame_byte : '0;
  assign RSP_VALID = (state == DONE);
  assign RSP_ERR   = (state == DONE) && err_q;
  assign RSP_DATA  = rsp_q;
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed bench for host_cmd_master: frame bytes, response capture, timeout,
// RX error, stalls and mid-frame reset.
module tb_host_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr, cmd_func;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  tx_byte, rx_byte;
  logic        tx_valid, tx_ready, rx_valid, rx_error;
  logic [15:0] rsp_data;
  logic        rsp_valid, rsp_err, busy;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  host_cmd_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_TYPE(cmd_type),
    .CMD_ADDR(cmd_addr), .CMD_DATA_A(cmd_a), .CMD_DATA_B(cmd_b), .CMD_FUNC(cmd_func),
    .TX_BYTE(tx_byte), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_BYTE(rx_byte), .RX_VALID(rx_valid), .RX_ERROR(rx_error),
    .RSP_DATA(rsp_data), .RSP_VALID(rsp_valid), .RSP_ERR(rsp_err), .BUSY(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive a command for one cycle; returns at the negedge where the first byte is visible.
  task automatic send_cmd(input logic [1:0] t, input logic [3:0] ad,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    cmd_type = t; cmd_addr = ad; cmd_a = a; cmd_b = b; cmd_func = f;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Check n frame bytes with TX_READY held high, one per cycle.
  task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
    logic [7:0] exp_b [3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_txv"}, {15'd0, tx_valid}, 16'd1);
      chk({tag, "_txb"}, {8'd0, tx_byte}, {8'd0, exp_b[i]});
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] op_b [4];
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_a = '0; cmd_b = '0;
    cmd_func = '0; tx_ready = 1'b0; rx_byte = '0; rx_valid = 1'b0; rx_error = 1'b0;
    @(negedge clk);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_txv",   {15'd0, tx_valid},  16'd0);
    chk("rst_txb",   {8'd0, tx_byte},    16'd0);
    chk("rst_rspv",  {15'd0, rsp_valid}, 16'd0);
    chk("rst_rspe",  {15'd0, rsp_err},   16'd0);
    chk("rst_data",  rsp_data,           16'd0);
    chk("rst_busy",  {15'd0, busy},      16'd0);
    rst = 1'b0;

    // RX activity while idle must be ignored
    rx_valid = 1'b1; rx_error = 1'b1; rx_byte = 8'hEE;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0;
    @(negedge clk);
    chk("idle_rx_busy", {15'd0, busy}, 16'd0);
    chk("idle_rx_data", rsp_data, 16'd0);

    // RF_WR addr=5 A=3C
    tx_ready = 1'b1;
    send_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0);
    chk("wr_busy", {15'd0, busy}, 16'd1);
    chk("wr_ready", {15'd0, cmd_ready}, 16'd0);
    check_frame("wr", 8'hAA, 8'h05, 8'h3C, 3);
    chk("wr_rspv", {15'd0, rsp_valid}, 16'd1);
    chk("wr_rspe", {15'd0, rsp_err}, 16'd0);
    chk("wr_data", rsp_data, 16'h0000);
    chk("wr_txv_off", {15'd0, tx_valid}, 16'd0);
    @(negedge clk);
    chk("wr_pulse_end", {15'd0, rsp_valid}, 16'd0);
    chk("wr_idle", {15'd0, cmd_ready}, 16'd1);

    // RF_RD addr=2, response 81
    send_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
    check_frame("rd", 8'hBB, 8'h02, 8'h00, 2);
    chk("rd_wait_txv", {15'd0, tx_valid}, 16'd0);
    chk("rd_wait_busy", {15'd0, busy}, 16'd1);
    chk("rd_wait_rspv", {15'd0, rsp_valid}, 16'd0);
    rx_valid = 1'b1; rx_byte = 8'h81;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rd_rspv", {15'd0, rsp_valid}, 16'd1);
    chk("rd_rspe", {15'd0, rsp_err}, 16'd0);
    chk("rd_data", rsp_data, 16'h0081);
    @(negedge clk);
    @(negedge clk);
    chk("rd_hold", rsp_data, 16'h0081);

    // ALU_OP with TX_READY toggling; accept clears RSP_DATA
    tx_ready = 1'b0;
    send_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'd0);
    chk("op_clear", rsp_data, 16'h0000);
    op_b[0] = 8'hCC; op_b[1] = 8'h12; op_b[2] = 8'h34; op_b[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk("op_txb", {8'd0, tx_byte}, {8'd0, op_b[i]});
      @(negedge clk);
      chk("op_stall_txv", {15'd0, tx_valid}, 16'd1);
      chk("op_stall_txb", {8'd0, tx_byte}, {8'd0, op_b[i]});
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    chk("op_wait_txv", {15'd0, tx_valid}, 16'd0);
    // a command while busy must not be queued
    cmd_valid = 1'b1; cmd_type = 2'd0;
    rx_valid = 1'b1; rx_byte = 8'h46;
    @(negedge clk);
    cmd_valid = 1'b0;
    rx_valid = 1'b0;
    chk("op_mid_rspv", {15'd0, rsp_valid}, 16'd0);
    chk("op_mid_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("op_rspv", {15'd0, rsp_valid}, 16'd1);
    chk("op_rspe", {15'd0, rsp_err}, 16'd0);
    chk("op_data", rsp_data, 16'h0046);
    @(negedge clk);
    chk("op_noqueue_txv", {15'd0, tx_valid}, 16'd0);
    chk("op_noqueue_ready", {15'd0, cmd_ready}, 16'd1);

    // ALU_NOP func=2, one byte then timeout after 16 idle cycles
    tx_ready = 1'b1;
    send_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd2);
    check_frame("nop", 8'hDD, 8'h02, 8'h00, 2);
    rx_valid = 1'b1; rx_byte = 8'h07;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("nop_early", {15'd0, rsp_valid}, 16'd0);
    end
    @(negedge clk);
    chk("nop_rspv", {15'd0, rsp_valid}, 16'd1);
    chk("nop_rspe", {15'd0, rsp_err}, 16'd1);
    chk("nop_data", rsp_data, 16'h0007);
    @(negedge clk);
    chk("nop_end", {15'd0, rsp_valid}, 16'd0);

    // RF_RD with byte and error together
    send_cmd(2'd1, 4'd9, 8'h00, 8'h00, 4'd0);
    check_frame("rde", 8'hBB, 8'h09, 8'h00, 2);
    rx_valid = 1'b1; rx_error = 1'b1; rx_byte = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0;
    chk("rde_rspv", {15'd0, rsp_valid}, 16'd1);
    chk("rde_rspe", {15'd0, rsp_err}, 16'd1);
    chk("rde_data", rsp_data, 16'h0055);
    @(negedge clk);

    // reset during second byte of ALU_OP
    send_cmd(2'd2, 4'd0, 8'hA1, 8'hB2, 4'd3);
    chk("abort_b0", {8'd0, tx_byte}, 16'h00CC);
    @(negedge clk);
    chk("abort_b1", {8'd0, tx_byte}, 16'h00A1);
    tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_txv", {15'd0, tx_valid}, 16'd0);
    chk("abort_txb", {8'd0, tx_byte}, 16'd0);
    chk("abort_ready", {15'd0, cmd_ready}, 16'd1);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_data", rsp_data, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_norsp", {15'd0, rsp_valid}, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8: UART byte width.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 Parameter FUNC_WIDTH, default 4: ALU function code width.
REQ-004 Parameter TIMEOUT_CYCLES, default 65535: maximum CLK cycles between response bytes.
REQ-005 The block SHALL have one clock, and its reset SHALL be synchronous and active-high. Ports are listed below.
REQ-006 CLK  input  1  sole clock; all logic on the rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 CMD_VALID  input  1  command request.
REQ-009 CMD_READY  output  1  block can accept a command.
REQ-010 CMD_TYPE  input  2  command type: 0 RF_WR, 1 RF_RD, 2 ALU_OP, 3 ALU_NOP.
REQ-011 CMD_ADDR  input  ADDR_WIDTH  register address.
REQ-012 CMD_DATA_A  input  DATA_WIDTH  RF write data, or ALU operand A.
REQ-013 CMD_DATA_B  input  DATA_WIDTH  ALU operand B.
REQ-014 CMD_FUNC  input  FUNC_WIDTH  ALU function code.
REQ-015 TX_BYTE  output  DATA_WIDTH  byte to the UART transmitter.
REQ-016 TX_VALID  output  1  TX_BYTE is valid.
REQ-017 TX_READY  input  1  UART transmitter accepts the byte.
REQ-018 RX_BYTE  input  DATA_WIDTH  byte from the UART receiver.
REQ-019 RX_VALID  input  1  single-cycle pulse; RX_BYTE is valid.
REQ-020 RX_ERROR  input  1  single-cycle parity or stop error pulse on a received byte.
REQ-021 RSP_DATA  output  2*DATA_WIDTH  response data: {byte1, byte0}.
REQ-022 RSP_VALID  output  1  single-cycle command-completion pulse.
REQ-023 RSP_ERR  output  1  qualifies RSP_VALID: timeout or RX_ERROR occurred.
REQ-024 BUSY  output  1  high in every state except IDLE.

Function
REQ-025 FSM states SHALL be IDLE, SEND, WAIT_RSP and DONE.
REQ-026 CMD_READY SHALL equal (state==IDLE); a command is accepted on CMD_VALID&&CMD_READY, all CMD_* fields are latched, and the FSM goes to SEND.
REQ-027 Frame sequence, in order of transmission:
- RF_WR: 0xAA, addr, A.
- RF_RD: 0xBB, addr.
- ALU_OP: 0xCC, A, B, func.
- ALU_NOP: 0xDD, func.
REQ-028 addr and func SHALL be zero-extended to DATA_WIDTH.
REQ-029 TX_VALID SHALL be high in SEND, starting the cycle after acceptance; TX_BYTE SHALL stay stable until the TX_VALID&&TX_READY handshake; the byte index increments on each handshake.
REQ-030 After the handshake of the last frame byte, the FSM SHALL go to DONE (RF_WR) or WAIT_RSP (other types); TX_VALID deasserts that same cycle.
REQ-031 Expected response byte count SHALL be RF_RD 1, ALU_OP 2, ALU_NOP 2.
REQ-032 In WAIT_RSP, each RX_VALID SHALL store RX_BYTE into byte slot k (first received byte goes to RSP_DATA[7:0]), increment k, and clear the timeout counter.
REQ-033 When the final expected byte arrives, the FSM SHALL go to DONE.
REQ-034 For RF_RD, RSP_DATA[15:8] SHALL be 0.
REQ-035 In WAIT_RSP, RX_ERROR SHALL set an error flag and the FSM SHALL go to DONE. If RX_VALID and RX_ERROR arrive together, the byte is stored and the error is still taken.
REQ-036 The timeout counter SHALL increment every WAIT_RSP cycle without RX_VALID. On reaching TIMEOUT_CYCLES-1, the error flag is set and the FSM goes to DONE; partial bytes are kept.
REQ-037 DONE SHALL last exactly one cycle with RSP_VALID=1 and RSP_ERR=error flag, then go to IDLE. RF_WR completes with RSP_DATA=0 and RSP_ERR=0.
REQ-038 RSP_DATA SHALL hold its value until the next command is accepted, then clear to 0.
REQ-039 RX_VALID and RX_ERROR outside WAIT_RSP SHALL be ignored.
REQ-040 CMD_VALID while BUSY SHALL be ignored; no queuing.
REQ-041 TX_READY held low SHALL stall SEND indefinitely; there is no timeout in SEND.

Reset
REQ-042 RST sampled high SHALL, at that edge, force state=IDLE, byte index=0, k=0, timeout counter=0, error flag=0, and all latched fields=0.
REQ-043 After that reset edge, outputs SHALL be CMD_READY=1, TX_VALID=0, TX_BYTE=0, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, BUSY=0.
REQ-044 RST mid-frame or mid-wait SHALL abort the command with no RSP_VALID pulse.

Verification
REQ-045 RF_WR addr=5, A=0x3C, TX_READY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; then RSP_VALID=1, RSP_DATA=0x0000, RSP_ERR=0.
REQ-046 RF_RD addr=2; RX 0x81 -> TX BB,02; then RSP_DATA=0x0081, RSP_ERR=0.
REQ-047 ALU_OP A=0x12, B=0x34, func=0, TX_READY toggling 1/0 -> TX bytes CC,12,34,00, each held stable while stalled; RX 0x46 then 0x00 -> RSP_DATA=0x0046.
REQ-048 ALU_NOP func=2 (TIMEOUT_CYCLES=16); RX 0x07 only -> after 16 idle cycles, RSP_VALID=1, RSP_ERR=1, RSP_DATA=0x0007.
REQ-049 RF_RD with RX_VALID and RX_ERROR together on byte 0x55 -> RSP_DATA=0x0055, RSP_ERR=1.
REQ-050 RST asserted during the second TX byte of ALU_OP -> next cycle TX_VALID=0, CMD_READY=1, and no RSP_VALID pulse.
